// File: rtl/external_memory_arbiter.sv
// Round-robin arbiter sharing the single external-memory port between the comm (C) and processor (P)
// requesters; one-deep request latch per port, one outstanding transaction, watchdog abort.
module external_memory_arbiter #(
  parameter int BW_BYTE_ADDR   = 26,
  parameter int BW_WORD_ADDR   = 24,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    reqC_i,
  input  logic                    reqBlockC_i,
  input  logic                    rwC_i,
  input  logic                    clearC_i,
  input  logic [BW_BYTE_ADDR:0]   addC_i,
  input  logic [31:0]             dataC_i,
  output logic [31:0]             dataC_o,
  output logic                    validC_o,
  output logic                    doneC_o,
  output logic                    readyC_o,
  output logic                    errC_o,
  input  logic                    reqP_i,
  input  logic                    reqBlockP_i,
  input  logic                    rwP_i,
  input  logic                    clearP_i,
  input  logic [BW_WORD_ADDR-1:0] addP_i,
  input  logic [31:0]             dataP_i,
  output logic [31:0]             dataP_o,
  output logic                    validP_o,
  output logic                    doneP_o,
  output logic                    readyP_o,
  output logic                    errP_o,
  output logic                    req3_o,
  output logic                    reqBlock3_o,
  output logic                    rw3_o,
  output logic                    clear3_o,
  output logic [BW_BYTE_ADDR:0]   add3_o,
  output logic [31:0]             data3_o,
  input  logic [31:0]             data3_i,
  input  logic                    ready3_i,
  input  logic                    done3_i,
  input  logic                    valid3_i
);

  localparam int AW  = BW_BYTE_ADDR + 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic GNT_C = 1'b0;
  localparam logic GNT_P = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1
  } state_t;

  state_t         st_q, st_d;
  logic           grant_q, grant_d;
  logic           lastGrant_q, lastGrant_d;
  logic [WDW-1:0] wdCnt_q, wdCnt_d;
  logic           req3_q, req3_d;
  logic           doneC_q, doneC_d, errC_q, errC_d;
  logic           doneP_q, doneP_d, errP_q, errP_d;
  logic           pendC_q, pendC_d, pendP_q, pendP_d;

  logic                    cBlk_q, cRw_q, cClr_q;
  logic [AW-1:0]           cAdd_q;
  logic [31:0]             cDat_q;
  logic                    pBlk_q, pRw_q, pClr_q;
  logic [BW_WORD_ADDR-1:0] pAdd_q;
  logic [31:0]             pDat_q;

  logic          captureC, captureP;
  logic          busy, gntC, gntP, finish;
  logic [AW-1:0] pAddByte;

  assign captureC = reqC_i && !pendC_q;
  assign captureP = reqP_i && !pendP_q;
  assign pAddByte = AW'({pAdd_q, 2'b00});

  // Request latches only load while their port is not already holding a request.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cBlk_q <= 1'b0;
      cRw_q  <= 1'b0;
      cClr_q <= 1'b0;
      cAdd_q <= '0;
      cDat_q <= '0;
      pBlk_q <= 1'b0;
      pRw_q  <= 1'b0;
      pClr_q <= 1'b0;
      pAdd_q <= '0;
      pDat_q <= '0;
    end else begin
      if (captureC) begin
        cBlk_q <= reqBlockC_i;
        cRw_q  <= rwC_i;
        cClr_q <= clearC_i;
        cAdd_q <= addC_i;
        cDat_q <= dataC_i;
      end
      if (captureP) begin
        pBlk_q <= reqBlockP_i;
        pRw_q  <= rwP_i;
        pClr_q <= clearP_i;
        pAdd_q <= addP_i;
        pDat_q <= dataP_i;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      st_q        <= ST_IDLE;
      grant_q     <= GNT_C;
      lastGrant_q <= GNT_P;
      wdCnt_q     <= '0;
      req3_q      <= 1'b0;
      doneC_q     <= 1'b0;
      errC_q      <= 1'b0;
      doneP_q     <= 1'b0;
      errP_q      <= 1'b0;
      pendC_q     <= 1'b0;
      pendP_q     <= 1'b0;
    end else begin
      st_q        <= st_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      wdCnt_q     <= wdCnt_d;
      req3_q      <= req3_d;
      doneC_q     <= doneC_d;
      errC_q      <= errC_d;
      doneP_q     <= doneP_d;
      errP_q      <= errP_d;
      pendC_q     <= pendC_d;
      pendP_q     <= pendP_d;
    end
  end

  always_comb begin
    st_d        = st_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    wdCnt_d     = wdCnt_q;
    req3_d      = 1'b0;
    doneC_d     = 1'b0;
    errC_d      = 1'b0;
    doneP_d     = 1'b0;
    errP_d      = 1'b0;
    pendC_d     = pendC_q | captureC;
    pendP_d     = pendP_q | captureP;
    finish      = 1'b0;

    case (st_q)
      ST_IDLE: begin
        if (ready3_i && (pendC_q || pendP_q)) begin
          // On a tie the port that was not served last wins.
          if (pendC_q && pendP_q) grant_d = ~lastGrant_q;
          else                    grant_d = pendP_q ? GNT_P : GNT_C;
          req3_d  = 1'b1;
          wdCnt_d = '0;
          st_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        finish = done3_i || (wdCnt_q == WD_LAST);
        if (finish) begin
          if (grant_q == GNT_C) begin
            doneC_d = 1'b1;
            errC_d  = !done3_i;
            pendC_d = 1'b0;
          end else begin
            doneP_d = 1'b1;
            errP_d  = !done3_i;
            pendP_d = 1'b0;
          end
          lastGrant_d = grant_q;
          st_d        = ST_IDLE;
        end else begin
          wdCnt_d = wdCnt_q + 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  assign busy = (st_q == ST_BUSY);
  assign gntC = busy && (grant_q == GNT_C);
  assign gntP = busy && (grant_q == GNT_P);

  assign req3_o      = req3_q;
  assign reqBlock3_o = (gntC && cBlk_q) || (gntP && pBlk_q);
  assign rw3_o       = (gntC && cRw_q) || (gntP && pRw_q);
  assign clear3_o    = (gntC && cClr_q) || (gntP && pClr_q);
  assign add3_o      = gntC ? cAdd_q : (gntP ? pAddByte : '0);
  assign data3_o     = gntC ? cDat_q : (gntP ? pDat_q : '0);

  assign dataC_o  = gntC ? data3_i : '0;
  assign validC_o = gntC && valid3_i;
  assign dataP_o  = gntP ? data3_i : '0;
  assign validP_o = gntP && valid3_i;

  assign doneC_o  = doneC_q;
  assign errC_o   = errC_q;
  assign readyC_o = !pendC_q;
  assign doneP_o  = doneP_q;
  assign errP_o   = errP_q;
  assign readyP_o = !pendP_q;

endmodule

// File: tb/tb_external_memory_arbiter.sv
// Directed bench for external_memory_arbiter: hand-computed expectations checked with immediate assertions.
module tb_external_memory_arbiter;

  localparam int BWB = 26;
  localparam int BWW = 24;
  localparam int TMO = 16;

  logic           clock = 1'b0;
  logic           reset_i;
  logic           reqC, reqBlockC, rwC, clearC;
  logic [BWB:0]   addC;
  logic [31:0]    dataCIn, dataCOut;
  logic           validC, doneC, readyC, errC;
  logic           reqP, reqBlockP, rwP, clearP;
  logic [BWW-1:0] addP;
  logic [31:0]    dataPIn, dataPOut;
  logic           validP, doneP, readyP, errP;
  logic           req3, reqBlock3, rw3, clear3;
  logic [BWB:0]   add3;
  logic [31:0]    data3Out, data3In;
  logic           ready3, done3, valid3;

  int assertCount = 0;
  int failCount   = 0;
  int req3Count   = 0;
  int doneCCount  = 0;
  int validCSeen  = 0;
  int c0;
  int d0;

  external_memory_arbiter #(
    .BW_BYTE_ADDR  (BWB),
    .BW_WORD_ADDR  (BWW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock_i    (clock),
    .reset_i    (reset_i),
    .reqC_i     (reqC),
    .reqBlockC_i(reqBlockC),
    .rwC_i      (rwC),
    .clearC_i   (clearC),
    .addC_i     (addC),
    .dataC_i    (dataCIn),
    .dataC_o    (dataCOut),
    .validC_o   (validC),
    .doneC_o    (doneC),
    .readyC_o   (readyC),
    .errC_o     (errC),
    .reqP_i     (reqP),
    .reqBlockP_i(reqBlockP),
    .rwP_i      (rwP),
    .clearP_i   (clearP),
    .addP_i     (addP),
    .dataP_i    (dataPIn),
    .dataP_o    (dataPOut),
    .validP_o   (validP),
    .doneP_o    (doneP),
    .readyP_o   (readyP),
    .errP_o     (errP),
    .req3_o     (req3),
    .reqBlock3_o(reqBlock3),
    .rw3_o      (rw3),
    .clear3_o   (clear3),
    .add3_o     (add3),
    .data3_o    (data3Out),
    .data3_i    (data3In),
    .ready3_i   (ready3),
    .done3_i    (done3),
    .valid3_i   (valid3)
  );

  always #5 clock = ~clock;

  // Pulse counters sampled on the inactive edge.
  always @(negedge clock) begin
    if (req3)   req3Count  <= req3Count + 1;
    if (doneC)  doneCCount <= doneCCount + 1;
    if (validC) validCSeen <= validCSeen + 1;
  end

  task applyStimulus();
    reqC = 1'b0; reqBlockC = 1'b0; rwC = 1'b0; clearC = 1'b0; addC = '0; dataCIn = '0;
    reqP = 1'b0; reqBlockP = 1'b0; rwP = 1'b0; clearP = 1'b0; addP = '0; dataPIn = '0;
    data3In = '0; ready3 = 1'b1; done3 = 1'b0; valid3 = 1'b0;
  endtask

  task tick();
    @(posedge clock);
    #1;
  endtask

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    applyStimulus();
    reset_i = 1'b0;
    valid3  = 1'b1;
    data3In = 32'h55;
    tick();
    tick();
    checkOutput("rst readyC", 32'(readyC), 32'd1);
    checkOutput("rst readyP", 32'(readyP), 32'd1);
    checkOutput("rst req3", 32'(req3), 32'd0);
    checkOutput("rst add3", 32'(add3), 32'd0);
    checkOutput("rst doneC", 32'(doneC), 32'd0);
    checkOutput("rst validP", 32'(validP), 32'd0);
    checkOutput("rst dataP", dataPOut, 32'd0);
    valid3  = 1'b0;
    data3In = '0;
    reset_i = 1'b1;

    // Single C read at 0x100, completion five cycles after the request pulse
    $display("[TB] single C read");
    c0 = req3Count;
    d0 = doneCCount;
    reqC = 1'b1; addC = 27'h100; rwC = 1'b0; clearC = 1'b1; reqBlockC = 1'b0; dataCIn = 32'hDEADBEEF;
    tick();
    reqC = 1'b0;
    checkOutput("t1 readyC low", 32'(readyC), 32'd0);
    checkOutput("t1 no req yet", 32'(req3), 32'd0);
    tick();
    checkOutput("t1 req3", 32'(req3), 32'd1);
    checkOutput("t1 add3", 32'(add3), 32'h100);
    checkOutput("t1 rw3", 32'(rw3), 32'd0);
    checkOutput("t1 clear3", 32'(clear3), 32'd1);
    checkOutput("t1 reqBlock3", 32'(reqBlock3), 32'd0);
    checkOutput("t1 data3", data3Out, 32'hDEADBEEF);
    tick();
    checkOutput("t1 req3 single", 32'(req3), 32'd0);
    checkOutput("t1 add3 held", 32'(add3), 32'h100);
    repeat (4) tick();
    checkOutput("t1 readyC still low", 32'(readyC), 32'd0);
    checkOutput("t1 doneC early", 32'(doneC), 32'd0);
    done3 = 1'b1;
    tick();
    done3 = 1'b0;
    checkOutput("t1 doneC", 32'(doneC), 32'd1);
    checkOutput("t1 readyC back", 32'(readyC), 32'd1);
    checkOutput("t1 errC", 32'(errC), 32'd0);
    tick();
    checkOutput("t1 doneC pulse", 32'(doneC), 32'd0);
    checkOutput("t1 add3 idle", 32'(add3), 32'd0);
    checkOutput("t1 req3 count", 32'(req3Count - c0), 32'd1);
    checkOutput("t1 doneC count", 32'(doneCCount - d0), 32'd1);

    // P block read: word 0x40 becomes byte 0x100, four beats routed to P only
    $display("[TB] P block read");
    reqP = 1'b1; addP = 24'h40; reqBlockP = 1'b1; rwP = 1'b1; clearP = 1'b0; dataPIn = 32'h12345678;
    tick();
    reqP = 1'b0;
    checkOutput("t2 readyP low", 32'(readyP), 32'd0);
    tick();
    checkOutput("t2 req3", 32'(req3), 32'd1);
    checkOutput("t2 add3", 32'(add3), 32'h100);
    checkOutput("t2 reqBlock3", 32'(reqBlock3), 32'd1);
    checkOutput("t2 rw3", 32'(rw3), 32'd1);
    checkOutput("t2 clear3", 32'(clear3), 32'd0);
    checkOutput("t2 data3", data3Out, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      tick();
      valid3  = 1'b1;
      data3In = 32'hA0 + 32'(i);
      #1;
      checkOutput("t2 validP", 32'(validP), 32'd1);
      checkOutput("t2 dataP", dataPOut, 32'hA0 + 32'(i));
      checkOutput("t2 validC", 32'(validC), 32'd0);
      checkOutput("t2 dataC", dataCOut, 32'd0);
    end
    valid3  = 1'b0;
    data3In = '0;
    done3   = 1'b1;
    tick();
    done3 = 1'b0;
    checkOutput("t2 doneP", 32'(doneP), 32'd1);
    checkOutput("t2 errP", 32'(errP), 32'd0);
    checkOutput("t2 validC never", 32'(validCSeen), 32'd0);
    tick();

    // Simultaneous C and P after reset, each reissuing on completion: C, P, C, P
    $display("[TB] round robin");
    reset_i = 1'b0;
    tick();
    reset_i = 1'b1;
    addC = 27'h200; reqBlockC = 1'b0; clearC = 1'b0;
    addP = 24'h10;  reqBlockP = 1'b0;
    c0 = req3Count;
    reqC = 1'b1; reqP = 1'b1;
    tick();
    reqC = 1'b0; reqP = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      checkOutput("t3 req3", 32'(req3), 32'd1);
      checkOutput("t3 grant add3", 32'(add3), (k % 2 == 0) ? 32'h200 : 32'h40);
      done3 = 1'b1;
      tick();
      done3 = 1'b0;
      if (k % 2 == 0) checkOutput("t3 doneC", 32'(doneC), 32'd1);
      else            checkOutput("t3 doneP", 32'(doneP), 32'd1);
      if (k < 2) begin
        if (k % 2 == 0) reqC = 1'b1;
        else            reqP = 1'b1;
      end
      tick();
      reqC = 1'b0; reqP = 1'b0;
    end
    checkOutput("t3 idle req3", 32'(req3), 32'd0);
    checkOutput("t3 readyC", 32'(readyC), 32'd1);
    checkOutput("t3 readyP", 32'(readyP), 32'd1);
    checkOutput("t3 req3 count", 32'(req3Count - c0), 32'd4);

    // Watchdog: P never completes, C latched meanwhile is served afterwards
    $display("[TB] watchdog");
    reqP = 1'b1; addP = 24'h20;
    tick();
    reqP = 1'b0;
    tick();
    checkOutput("t4 req3 P", 32'(req3), 32'd1);
    checkOutput("t4 add3 P", 32'(add3), 32'h80);
    reqC = 1'b1; addC = 27'h300;
    tick();
    reqC = 1'b0;
    repeat (14) tick();
    checkOutput("t4 doneP early", 32'(doneP), 32'd0);
    checkOutput("t4 errP early", 32'(errP), 32'd0);
    checkOutput("t4 readyP low", 32'(readyP), 32'd0);
    tick();
    checkOutput("t4 doneP", 32'(doneP), 32'd1);
    checkOutput("t4 errP", 32'(errP), 32'd1);
    checkOutput("t4 readyP", 32'(readyP), 32'd1);
    tick();
    checkOutput("t4 errP pulse", 32'(errP), 32'd0);
    checkOutput("t4 req3 C", 32'(req3), 32'd1);
    checkOutput("t4 add3 C", 32'(add3), 32'h300);
    done3 = 1'b1;
    tick();
    done3 = 1'b0;
    checkOutput("t4 doneC", 32'(doneC), 32'd1);
    checkOutput("t4 errC", 32'(errC), 32'd0);
    tick();

    // Re-request while pending is dropped; memory not ready holds the grant
    $display("[TB] request while pending");
    c0 = req3Count;
    ready3 = 1'b0;
    reqC = 1'b1; addC = 27'h500;
    tick();
    addC = 27'h600;
    tick();
    reqC = 1'b0;
    checkOutput("t5 held req3", 32'(req3), 32'd0);
    checkOutput("t5 readyC", 32'(readyC), 32'd0);
    ready3 = 1'b1;
    tick();
    checkOutput("t5 req3", 32'(req3), 32'd1);
    checkOutput("t5 original add3", 32'(add3), 32'h500);
    done3 = 1'b1;
    tick();
    done3 = 1'b0;
    checkOutput("t5 doneC", 32'(doneC), 32'd1);
    tick();
    checkOutput("t5 no second req", 32'(req3), 32'd0);
    checkOutput("t5 readyC", 32'(readyC), 32'd1);
    checkOutput("t5 req3 count", 32'(req3Count - c0), 32'd1);

    // Asynchronous reset in the middle of a transaction
    $display("[TB] reset during busy");
    reqC = 1'b1; addC = 27'h700;
    tick();
    reqC = 1'b0;
    tick();
    checkOutput("t6 req3", 32'(req3), 32'd1);
    tick();
    valid3 = 1'b1; data3In = 32'hAA;
    #1;
    checkOutput("t6 validC busy", 32'(validC), 32'd1);
    checkOutput("t6 dataC busy", dataCOut, 32'hAA);
    #1;
    reset_i = 1'b0;
    #1;
    checkOutput("t6 async readyC", 32'(readyC), 32'd1);
    checkOutput("t6 async add3", 32'(add3), 32'd0);
    checkOutput("t6 async validC", 32'(validC), 32'd0);
    checkOutput("t6 async dataC", dataCOut, 32'd0);
    tick();
    reset_i = 1'b1;
    valid3 = 1'b0; data3In = '0;
    done3 = 1'b1;
    tick();
    done3 = 1'b0;
    checkOutput("t6 no doneC", 32'(doneC), 32'd0);
    checkOutput("t6 no errC", 32'(errC), 32'd0);
    checkOutput("t6 readyC", 32'(readyC), 32'd1);
    checkOutput("t6 readyP", 32'(readyP), 32'd1);
    tick();
    checkOutput("t6 idle req3", 32'(req3), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
